// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, shift-control
// encodings and the FSM state enumeration.
package alu_pkg;

  // Operation codes on op_i; 101-111 are illegal.
  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpMul = 3'b011;
  localparam logic [2:0] OpDiv = 3'b100;

  // Shift-register control encodings shared by hs_o and ls_o.
  localparam logic [1:0] ShHold = 2'b00;
  localparam logic [1:0] ShShr  = 2'b01;
  localparam logic [1:0] ShShl  = 2'b10;
  localparam logic [1:0] ShLoad = 2'b11;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StLdh  = 4'd1,
    StExe  = 4'd2,
    StLdl  = 4'd3,
    StClrh = 4'd4,
    StDsh  = 4'd5,
    StDsub = 4'd6,
    StDfin = 4'd7,
    StMop  = 4'd8,
    StMsh  = 4'd9,
    StDone = 4'd10
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OpDiv;
  endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// Iteration counter for the MUL/DIV loops.
// Ports:
//   clk_i   - clock
//   clr_i   - asynchronous active-high reset
//   clear_i - synchronous clear to zero
//   inc_i   - increment by one
//   tc_o    - terminal count, high while the count equals NBITS-1
module alu_seq_cnt #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned CNTW  = 3
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNTW'(NBITS - 1));

endmodule

// File: rtl/alu_seq.sv
// Control sequencer for the accumulator/ALU block. A start pulse in idle runs
// one ADD/SUB/AND, shift-and-add MUL or restoring DIV, emitting the per-cycle
// control word. Outputs are decoded from the state register only.
// Ports:
//   clk_i, clr_i        - clock, asynchronous active-high reset
//   start_i, op_i       - begin operation / opcode (sampled in idle)
//   breg_zero_i         - B register is zero (sampled with start)
//   ah_inen_o, ah_reset_o, hs_o, ls_o - A-high/A-low register controls
//   s_add_o .. s_div_o  - ALU function selects
//   acc_oen_o           - accumulator output enable
//   busy_o, done_o, err_o - status
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned NBITS = 4,
  parameter int unsigned CNTW  = 3
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       start_i,
  input  logic [2:0] op_i,
  input  logic       breg_zero_i,
  output logic       ah_inen_o,
  output logic       ah_reset_o,
  output logic [1:0] hs_o,
  output logic [1:0] ls_o,
  output logic       s_add_o,
  output logic       s_sub_o,
  output logic       s_and_o,
  output logic       s_mul_o,
  output logic       s_div_o,
  output logic       acc_oen_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  state_e     state_q;
  logic [2:0] op_q;
  logic       err_q;
  logic       cnt_tc;

  alu_seq_cnt #(
    .NBITS(NBITS),
    .CNTW (CNTW)
  ) u_cnt (
    .clk_i  (clk_i),
    .clr_i  (clr_i),
    .clear_i(state_q == StClrh),
    .inc_i  ((state_q == StDsub) || (state_q == StMsh)),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            op_q <= op_i;
            // Illegal op or divide by zero skips straight to DONE with no strobes.
            if (op_legal(op_i) && !((op_i == OpDiv) && breg_zero_i)) begin
              state_q <= StLdh;
              err_q   <= 1'b0;
            end else begin
              state_q <= StDone;
              err_q   <= 1'b1;
            end
          end
        end
        StLdh:   state_q <= ((op_q == OpMul) || (op_q == OpDiv)) ? StLdl : StExe;
        StExe:   state_q <= StDone;
        StLdl:   state_q <= StClrh;
        StClrh:  state_q <= (op_q == OpMul) ? StMop : StDsh;
        StDsh:   state_q <= StDsub;
        StDsub:  state_q <= cnt_tc ? StDfin : StDsh;
        StDfin:  state_q <= StDone;
        StMop:   state_q <= StMsh;
        StMsh:   state_q <= cnt_tc ? StDone : StMop;
        StDone: begin
          state_q <= StIdle;
          err_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ah_inen_o  = 1'b0;
    ah_reset_o = 1'b0;
    hs_o       = ShHold;
    ls_o       = ShHold;
    s_add_o    = 1'b0;
    s_sub_o    = 1'b0;
    s_and_o    = 1'b0;
    s_mul_o    = 1'b0;
    s_div_o    = 1'b0;
    acc_oen_o  = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    err_o      = 1'b0;
    case (state_q)
      StLdh: begin
        ah_inen_o = 1'b1;
        hs_o      = ShLoad;
      end
      StExe: begin
        hs_o    = ShLoad;
        s_add_o = (op_q == OpAdd);
        s_sub_o = (op_q == OpSub);
        s_and_o = (op_q == OpAnd);
      end
      StLdl:  ls_o = ShLoad;
      StClrh: ah_reset_o = 1'b1;
      StDsh: begin
        hs_o = ShShl;
        ls_o = ShShl;
      end
      StDsub: begin
        hs_o    = ShLoad;
        s_div_o = 1'b1;
      end
      // Shift the quotient bit into A-low.
      StDfin: ls_o = ShShl;
      StMop: begin
        hs_o    = ShLoad;
        s_mul_o = 1'b1;
      end
      StMsh: begin
        hs_o = ShShr;
        ls_o = ShShr;
      end
      StDone: begin
        acc_oen_o = 1'b1;
        done_o    = 1'b1;
        err_o     = err_q;
      end
      default: begin
        acc_oen_o = 1'b1;
        busy_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  typedef logic [14:0] ctl_t;

  // {ah_inen, ah_reset, hs, ls, s_add, s_sub, s_and, s_mul, s_div, acc_oen, busy, done, err}
  localparam ctl_t W_IDLE  = {1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctl_t W_LDH   = {1'b1, 1'b0, 2'b11, 2'b00, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_LDL   = {1'b0, 1'b0, 2'b00, 2'b11, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_CLRH  = {1'b0, 1'b1, 2'b00, 2'b00, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_DSH   = {1'b0, 1'b0, 2'b10, 2'b10, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_DSUB  = {1'b0, 1'b0, 2'b11, 2'b00, 5'b00001, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_DFIN  = {1'b0, 1'b0, 2'b00, 2'b10, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_MOP   = {1'b0, 1'b0, 2'b11, 2'b00, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_MSH   = {1'b0, 1'b0, 2'b01, 2'b01, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_EADD  = {1'b0, 1'b0, 2'b11, 2'b00, 5'b10000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_ESUB  = {1'b0, 1'b0, 2'b11, 2'b00, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_EAND  = {1'b0, 1'b0, 2'b11, 2'b00, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t W_DONE  = {1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctl_t W_DERR  = {1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b1};

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic       breg_zero = 1'b0;
  logic       ah_inen, ah_reset, s_add, s_sub, s_and, s_mul, s_div;
  logic       acc_oen, busy, done, err;
  logic [1:0] hs, ls;

  int checks = 0;
  int errors = 0;

  alu_seq dut (
    .clk_i      (clk),
    .clr_i      (clr),
    .start_i    (start),
    .op_i       (op),
    .breg_zero_i(breg_zero),
    .ah_inen_o  (ah_inen),
    .ah_reset_o (ah_reset),
    .hs_o       (hs),
    .ls_o       (ls),
    .s_add_o    (s_add),
    .s_sub_o    (s_sub),
    .s_and_o    (s_and),
    .s_mul_o    (s_mul),
    .s_div_o    (s_div),
    .acc_oen_o  (acc_oen),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  function automatic ctl_t obs();
    return {ah_inen, ah_reset, hs, ls, s_add, s_sub, s_and, s_mul, s_div,
            acc_oen, busy, done, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; afterwards scramble op/breg_zero to prove they were latched.
  task automatic kick(input logic [2:0] o, input logic bz);
    start = 1'b1;
    op = o;
    breg_zero = bz;
    step();
    start = 1'b0;
    op = 3'b111;
    breg_zero = 1'b1;
  endtask

  task automatic test_reset();
    ctl_t got;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = obs();
    checks++;
    if (got !== W_IDLE) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", got, W_IDLE);
    end
    clr = 1'b0;
    step();
    got = obs();
    checks++;
    if (got !== W_IDLE) begin
      errors++;
      $display("FAIL reset_released: got %h want %h", got, W_IDLE);
    end
  endtask

  task automatic test_div();
    ctl_t exp[$];
    ctl_t got;
    int busy_n = 0;
    int done_at = -1;
    exp = {W_LDH, W_LDL, W_CLRH};
    repeat (4) begin
      exp.push_back(W_DSH);
      exp.push_back(W_DSUB);
    end
    exp.push_back(W_DFIN);
    exp.push_back(W_DONE);
    exp.push_back(W_IDLE);
    kick(3'b100, 1'b0);
    foreach (exp[i]) begin
      if (i > 0) step();
      got = obs();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL div cycle %0d: got %h want %h", i, got, exp[i]);
      end
      busy_n += int'(busy);
      if (done && done_at < 0) done_at = i;
    end
    checks++;
    if (busy_n !== 13) begin
      errors++;
      $display("FAIL div_busy_cycles: got %0d want 13", busy_n);
    end
    checks++;
    if (done_at !== 12) begin
      errors++;
      $display("FAIL div_done_index: got %0d want 12", done_at);
    end
  endtask

  task automatic test_mul();
    ctl_t exp[$];
    ctl_t got;
    int busy_n = 0;
    exp = {W_LDH, W_LDL, W_CLRH};
    repeat (4) begin
      exp.push_back(W_MOP);
      exp.push_back(W_MSH);
    end
    exp.push_back(W_DONE);
    exp.push_back(W_IDLE);
    kick(3'b011, 1'b0);
    foreach (exp[i]) begin
      if (i > 0) step();
      got = obs();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL mul cycle %0d: got %h want %h", i, got, exp[i]);
      end
      busy_n += int'(busy);
    end
    checks++;
    if (busy_n !== 12) begin
      errors++;
      $display("FAIL mul_busy_cycles: got %0d want 12", busy_n);
    end
  endtask

  task automatic test_errors();
    logic [2:0] ops[3] = '{3'b100, 3'b111, 3'b101};
    logic       bzs[3] = '{1'b1, 1'b0, 1'b0};
    ctl_t got;
    for (int k = 0; k < 3; k++) begin
      kick(ops[k], bzs[k]);
      got = obs();
      checks++;
      if (got !== W_DERR) begin
        errors++;
        $display("FAIL err_done op=%b bz=%b: got %h want %h", ops[k], bzs[k], got, W_DERR);
      end
      step();
      got = obs();
      checks++;
      if (got !== W_IDLE) begin
        errors++;
        $display("FAIL err_idle op=%b: got %h want %h", ops[k], got, W_IDLE);
      end
    end
  endtask

  task automatic test_logic_ops();
    logic [2:0] ops[3] = '{3'b000, 3'b001, 3'b010};
    ctl_t       exe[3] = '{W_EADD, W_ESUB, W_EAND};
    ctl_t exp[$];
    ctl_t got;
    for (int k = 0; k < 3; k++) begin
      exp = {W_LDH, exe[k], W_DONE, W_IDLE, W_IDLE};
      kick(ops[k], 1'b0);
      foreach (exp[i]) begin
        if (i > 0) step();
        got = obs();
        checks++;
        if (got !== exp[i]) begin
          errors++;
          $display("FAIL op%0d cycle %0d: got %h want %h", k, i, got, exp[i]);
        end
        // Hold start high through EXE and DONE; neither may launch a new op.
        if (i == 1) begin
          start = 1'b1;
          op = 3'b000;
          breg_zero = 1'b0;
        end
        if (i == 3) start = 1'b0;
      end
    end
  endtask

  task automatic test_clr_mid();
    ctl_t pre[7] = '{W_LDH, W_LDL, W_CLRH, W_DSH, W_DSUB, W_DSH, W_DSUB};
    ctl_t exp[$];
    ctl_t got;
    int busy_n = 0;
    kick(3'b100, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      got = obs();
      checks++;
      if (got !== pre[i]) begin
        errors++;
        $display("FAIL clr_pre cycle %0d: got %h want %h", i, got, pre[i]);
      end
    end
    clr = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== W_IDLE) begin
      errors++;
      $display("FAIL clr_async: got %h want %h", got, W_IDLE);
    end
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      got = obs();
      checks++;
      if (got !== W_IDLE) begin
        errors++;
        $display("FAIL clr_no_done cycle %0d: got %h want %h", i, got, W_IDLE);
      end
    end
    exp = {W_LDH, W_LDL, W_CLRH};
    repeat (4) begin
      exp.push_back(W_DSH);
      exp.push_back(W_DSUB);
    end
    exp.push_back(W_DFIN);
    exp.push_back(W_DONE);
    exp.push_back(W_IDLE);
    kick(3'b100, 1'b0);
    foreach (exp[i]) begin
      if (i > 0) step();
      got = obs();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL div_after_clr cycle %0d: got %h want %h", i, got, exp[i]);
      end
      busy_n += int'(busy);
    end
    checks++;
    if (busy_n !== 13) begin
      errors++;
      $display("FAIL div_after_clr_busy: got %0d want 13", busy_n);
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_mul();
    test_errors();
    test_logic_ops();
    test_clr_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
